// File: rtl/traffic_frontend_pkg.sv
// Purpose : shared state encodings for the traffic-light request front end.
// Latency : n/a (types only).
// Backpressure: n/a (types only).
// Contents: walk_state_t (pedestrian request FSM), sen_state_t (vehicle request FSM).
package traffic_frontend_pkg;

   // Pedestrian request FSM: idle, request pending, waiting for button release.
   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_REQ  = 2'd1,
      W_REL  = 2'd2
   } walk_state_t;

   // Vehicle request FSM: idle, counting presence ticks, request pending,
   // waiting for the vehicle to leave.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CNT  = 2'd1,
      S_REQ  = 2'd2,
      S_HOLD = 2'd3
   } sen_state_t;

endpackage

// File: rtl/input_debouncer.sv
// Purpose : 2-flop synchroniser followed by a stability debouncer for one raw pin.
// Latency : db follows a stable raw change DEB_CYCLES+2 edges after it is first sampled.
// Backpressure: none; free-running, output is a level.
// Ports   : clk, reset (async active-low), raw (asynchronous pin), db (debounced level).
module input_debouncer #(
   parameter int DEB_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic db
);
   import traffic_frontend_pkg::*;

   localparam int CW = $clog2(DEB_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;

   // Plain two-flop chain; nothing combinational between the stages.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   // cnt measures how long sync2 has disagreed with db; any agreement
   // restarts the measurement, so short glitches never reach db.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
         db  <= 1'b0;
      end else if (sync2 == db) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         db  <= sync2;
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/traffic_request_frontend.sv
// Purpose : conditions button/loop-sensor pins and issues held requests to the light controller.
// Latency : walk_req rises DEB_CYCLES+3 edges after a clean press; sen_req the edge after the qualifying tick.
// Backpressure: requests are held until the matching one-cycle ack; acks outside a pending request are dropped.
// Ports   : clk, reset (async active-low), tick (slow strobe), walk_btn, sensor_raw (raw pins),
//           walk_ack, sen_ack (service pulses), walk_req, sen_req (held requests), walk_db, sensor_db (LED levels).
module traffic_request_frontend #(
   parameter int DEB_CYCLES     = 4,
   parameter int PRESENCE_TICKS = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic tick,
   input  logic walk_btn,
   input  logic sensor_raw,
   input  logic walk_ack,
   input  logic sen_ack,
   output logic walk_req,
   output logic sen_req,
   output logic walk_db,
   output logic sensor_db
);
   import traffic_frontend_pkg::*;

   localparam int PW = $clog2(PRESENCE_TICKS + 1);
   localparam logic [PW-1:0] PCNT_LAST = PW'(PRESENCE_TICKS - 1);

   walk_state_t   w_state, w_next;
   sen_state_t    s_state, s_next;
   logic [PW-1:0] pcnt, pcnt_next;

   input_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_walk_deb (
      .clk   (clk),
      .reset (reset),
      .raw   (walk_btn),
      .db    (walk_db)
   );

   input_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_sensor_deb (
      .clk   (clk),
      .reset (reset),
      .raw   (sensor_raw),
      .db    (sensor_db)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         w_state <= W_IDLE;
         s_state <= S_IDLE;
         pcnt    <= '0;
      end else begin
         w_state <= w_next;
         s_state <= s_next;
         pcnt    <= pcnt_next;
      end
   end

   // Walk FSM. W_REL absorbs a held button so one press yields one request.
   always_comb begin
      w_next = w_state;
      case (w_state)
         W_IDLE: if (walk_db) w_next = W_REQ;
         W_REQ:  if (walk_ack) w_next = walk_db ? W_REL : W_IDLE;
         W_REL:  if (!walk_db) w_next = W_IDLE;
         default: w_next = W_IDLE;
      endcase
   end

   // Sensor FSM. Presence is only counted from S_CNT, so a tick landing on
   // the same edge that sensor_db rises is not counted.
   always_comb begin
      s_next    = s_state;
      pcnt_next = pcnt;
      case (s_state)
         S_IDLE: begin
            if (sensor_db) begin
               s_next    = S_CNT;
               pcnt_next = '0;
            end
         end
         S_CNT: begin
            if (!sensor_db) begin
               s_next = S_IDLE;
            end else if (tick) begin
               if (pcnt == PCNT_LAST) s_next = S_REQ;
               else                   pcnt_next = pcnt + 1'b1;
            end
         end
         // Request stays latched even if the vehicle leaves before service.
         S_REQ:  if (sen_ack) s_next = sensor_db ? S_HOLD : S_IDLE;
         S_HOLD: if (!sensor_db) s_next = S_IDLE;
         default: s_next = S_IDLE;
      endcase
   end

   // Moore decode straight from the async-reset state flops, so reset drops
   // the requests without waiting for a clock.
   assign walk_req = (w_state == W_REQ);
   assign sen_req  = (s_state == S_REQ);

endmodule
